// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates i-cache read, d-cache read and d-cache write
// line requests onto one single-port word array; reads return fixed-latency bursts.
module mem_responder #(
  parameter int ADDR_WIDTH      = 26,
  parameter int DATA_WIDTH      = 32,
  parameter int BURST_LEN       = 4,
  parameter int MEM_LATENCY     = 4,
  parameter int MEM_INDEX_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req_valid,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_req_ready,
  output logic                  ic_rsp_valid,
  output logic [DATA_WIDTH-1:0] ic_rsp_data,
  output logic                  ic_rsp_last,
  input  logic                  dcr_req_valid,
  input  logic [ADDR_WIDTH-1:0] dcr_req_addr,
  output logic                  dcr_req_ready,
  output logic                  dcr_rsp_valid,
  output logic [DATA_WIDTH-1:0] dcr_rsp_data,
  output logic                  dcr_rsp_last,
  input  logic                  dcw_req_valid,
  input  logic [ADDR_WIDTH-1:0] dcw_req_addr,
  output logic                  dcw_req_ready,
  input  logic                  dcw_data_valid,
  input  logic [DATA_WIDTH-1:0] dcw_data,
  output logic                  dcw_data_ready,
  output logic                  dcw_done,
  output logic [2:0]            dbg_state
);

  // Handshake: a request or write beat transfers on a rising edge where its
  // valid and ready are both high; read beats have no back-pressure.

  localparam int OFF = $clog2(BURST_LEN);
  localparam int LW  = MEM_INDEX_WIDTH - OFF;
  localparam int CW  = $clog2(MEM_LATENCY) + 1;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(BURST_LEN - 1);
  localparam logic [CW-1:0]  LAT_LOAD  = CW'(MEM_LATENCY - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_RD_BURST = 3'd2;
  localparam logic [2:0] S_WR_BURST = 3'd3;
  localparam logic [2:0] S_WR_DONE  = 3'd4;

  logic [2:0]            state;
  logic [OFF-1:0]        beat_cnt;
  logic [OFF-1:0]        beat_nxt;
  logic [CW-1:0]         lat_cnt;
  logic [1:0]            starve_cnt;
  logic [LW-1:0]         line_q;
  logic                  rd_is_ic;
  logic [DATA_WIDTH-1:0] ic_data_q;
  logic [DATA_WIDTH-1:0] dcr_data_q;

  logic [DATA_WIDTH-1:0] mem [2**MEM_INDEX_WIDTH];

  logic                       idle;
  logic                       force_ic;
  logic                       gnt_ic;
  logic                       gnt_dcr;
  logic                       gnt_dcw;
  logic [ADDR_WIDTH-1:0]      gnt_addr;
  logic [LW-1:0]              gnt_line;
  logic [MEM_INDEX_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0]      rd_word;
  logic                       rd_load;
  logic                       wr_en;
  logic                       unused_addr_bits;

  assign idle     = (state == S_IDLE);
  // Two back-to-back d-side wins while ic waited hand the next slot to ic.
  assign force_ic = (starve_cnt == 2'd2) && ic_req_valid;
  assign gnt_dcw  = idle && !force_ic && dcw_req_valid;
  assign gnt_dcr  = idle && !force_ic && !dcw_req_valid && dcr_req_valid;
  assign gnt_ic   = idle && ic_req_valid && (force_ic || (!dcw_req_valid && !dcr_req_valid));

  always_comb begin
    gnt_addr = ic_req_addr;
    if (gnt_dcw)      gnt_addr = dcw_req_addr;
    else if (gnt_dcr) gnt_addr = dcr_req_addr;
  end

  // Line index drops the byte offset and the in-line word bits; upper bits wrap.
  assign gnt_line         = gnt_addr[2+OFF +: LW];
  assign unused_addr_bits = ^gnt_addr;

  assign beat_nxt = beat_cnt + OFF'(1);

  always_comb begin
    rd_idx = {line_q, beat_nxt};
    if (state == S_RD_WAIT) rd_idx = {line_q, beat_cnt};
  end
  assign rd_word = mem[rd_idx];

  // The data register is filled one cycle ahead of each presented beat.
  assign rd_load = ((state == S_RD_WAIT) && (lat_cnt == CW'(1))) ||
                   ((state == S_RD_BURST) && (beat_cnt != LAST_BEAT));
  assign wr_en   = (state == S_WR_BURST) && dcw_data_valid;

  always_ff @(posedge clk) begin
    if (wr_en) mem[{line_q, beat_cnt}] <= dcw_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      line_q     <= '0;
      rd_is_ic   <= 1'b0;
      ic_data_q  <= '0;
      dcr_data_q <= '0;
    end else begin
      if (rd_load) begin
        if (rd_is_ic) ic_data_q  <= rd_word;
        else          dcr_data_q <= rd_word;
      end
      case (state)
        S_IDLE: begin
          beat_cnt <= '0;
          if (gnt_ic || gnt_dcr || gnt_dcw) line_q <= gnt_line;
          if (gnt_ic)                         starve_cnt <= '0;
          else if (gnt_dcw || gnt_dcr)        starve_cnt <= ic_req_valid ? starve_cnt + 2'd1 : 2'd0;
          if (gnt_dcw) begin
            state <= S_WR_BURST;
          end else if (gnt_dcr || gnt_ic) begin
            state    <= S_RD_WAIT;
            lat_cnt  <= LAT_LOAD;
            rd_is_ic <= gnt_ic;
          end
        end
        S_RD_WAIT: begin
          lat_cnt <= lat_cnt - CW'(1);
          if (lat_cnt == CW'(1)) state <= S_RD_BURST;
        end
        S_RD_BURST: begin
          if (beat_cnt == LAST_BEAT) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_nxt;
          end
        end
        S_WR_BURST: begin
          if (dcw_data_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= S_WR_DONE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_nxt;
            end
          end
        end
        S_WR_DONE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign ic_req_ready   = gnt_ic;
  assign dcr_req_ready  = gnt_dcr;
  assign dcw_req_ready  = gnt_dcw;
  assign ic_rsp_valid   = (state == S_RD_BURST) && rd_is_ic;
  assign dcr_rsp_valid  = (state == S_RD_BURST) && !rd_is_ic;
  assign ic_rsp_last    = ic_rsp_valid && (beat_cnt == LAST_BEAT);
  assign dcr_rsp_last   = dcr_rsp_valid && (beat_cnt == LAST_BEAT);
  assign ic_rsp_data    = ic_data_q;
  assign dcr_rsp_data   = dcr_data_q;
  assign dcw_data_ready = (state == S_WR_BURST);
  assign dcw_done       = (state == S_WR_DONE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of line reads plus hand-written
// sequences for write stalls, arbitration, starvation and mid-burst reset.
module tb_mem_responder;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int BL  = 4;
  localparam int LAT = 4;

  typedef logic [BL-1:0][DW-1:0] line_t;
  typedef struct {
    logic          is_ic;
    logic [AW-1:0] addr;
    line_t         exp;
  } rd_vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req_valid, ic_req_ready, ic_rsp_valid, ic_rsp_last;
  logic [AW-1:0] ic_req_addr;
  logic [DW-1:0] ic_rsp_data;
  logic          dcr_req_valid, dcr_req_ready, dcr_rsp_valid, dcr_rsp_last;
  logic [AW-1:0] dcr_req_addr;
  logic [DW-1:0] dcr_rsp_data;
  logic          dcw_req_valid, dcw_req_ready, dcw_data_valid, dcw_data_ready, dcw_done;
  logic [AW-1:0] dcw_req_addr;
  logic [DW-1:0] dcw_data;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  line_t line_a, line_b, line_d, line_e;
  rd_vec_t vecs[6];

  mem_responder dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_last(ic_rsp_last),
    .dcr_req_valid(dcr_req_valid), .dcr_req_addr(dcr_req_addr), .dcr_req_ready(dcr_req_ready),
    .dcr_rsp_valid(dcr_rsp_valid), .dcr_rsp_data(dcr_rsp_data), .dcr_rsp_last(dcr_rsp_last),
    .dcw_req_valid(dcw_req_valid), .dcw_req_addr(dcw_req_addr), .dcw_req_ready(dcw_req_ready),
    .dcw_data_valid(dcw_data_valid), .dcw_data(dcw_data), .dcw_data_ready(dcw_data_ready),
    .dcw_done(dcw_done), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic wait_ready(input int who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((who == 0 && ic_req_ready) || (who == 1 && dcr_req_ready) || (who == 2 && dcw_req_ready)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input line_t data, input int gap);
    bit ok;
    dcw_req_addr  = addr;
    dcw_req_valid = 1'b1;
    #1;
    wait_ready(2, ok);
    check("wr_grant", ok, 1);
    if (!ok) begin
      dcw_req_valid = 1'b0;
      return;
    end
    tick();
    dcw_req_valid = 1'b0;
    for (int b = 0; b < BL; b++) begin
      if (b == 2 && gap > 0) begin
        dcw_data_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          check("wr_ready_stall", dcw_data_ready, 1);
          check("wr_done_stall", dcw_done, 0);
          tick();
        end
      end
      dcw_data_valid = 1'b1;
      dcw_data       = data[b];
      check("wr_ready_beat", dcw_data_ready, 1);
      tick();
    end
    dcw_data_valid = 1'b0;
    check("wr_done_pulse", dcw_done, 1);
    check("wr_ready_after", dcw_data_ready, 0);
    tick();
    check("wr_done_once", dcw_done, 0);
    check("wr_idle", dbg_state, 0);
  endtask

  task automatic do_read(input logic is_ic, input logic [AW-1:0] addr, input line_t exp);
    bit ok;
    logic [DW-1:0] e;
    if (is_ic) begin ic_req_addr = addr; ic_req_valid = 1'b1; end
    else       begin dcr_req_addr = addr; dcr_req_valid = 1'b1; end
    #1;
    wait_ready(is_ic ? 0 : 1, ok);
    check("rd_grant", ok, 1);
    if (!ok) begin
      ic_req_valid  = 1'b0;
      dcr_req_valid = 1'b0;
      return;
    end
    for (int b = 0; b < BL; b++) exp_q.push_back(exp[b]);
    tick();
    ic_req_valid  = 1'b0;
    dcr_req_valid = 1'b0;
    for (int k = 1; k < LAT + BL; k++) begin
      check("rd_valid", {ic_rsp_valid, dcr_rsp_valid},
            (k >= LAT) ? (is_ic ? 32'd2 : 32'd1) : 32'd0);
      if (k >= LAT && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_data", is_ic ? ic_rsp_data : dcr_rsp_data, e);
        check("rd_last", is_ic ? ic_rsp_last : dcr_rsp_last, (k == LAT + BL - 1) ? 1 : 0);
      end else if (k < LAT) begin
        check("rd_last_early", {ic_rsp_last, dcr_rsp_last}, 0);
      end
      if (k < LAT + BL - 1) tick();
    end
    tick();
    check("rd_idle_after", dbg_state, 0);
    check("rd_valid_after", {ic_rsp_valid, dcr_rsp_valid}, 0);
  endtask

  // One arbitration round from IDLE; grant must be immediate and one-hot.
  task automatic arb_step(input int exp_who, input bit drop);
    int who;
    who = -1;
    check("arb_immediate", {dcw_req_ready, dcr_req_ready, ic_req_ready} != 3'b000, 1);
    for (int i = 0; i < 40 && who < 0; i++) begin
      if (ic_req_ready)       who = 0;
      else if (dcr_req_ready) who = 1;
      else if (dcw_req_ready) who = 2;
      if (who < 0) tick();
    end
    check("arb_onehot", {dcw_req_ready, dcr_req_ready, ic_req_ready}, 32'd1 << exp_who);
    if (who < 0) return;
    tick();
    if (drop) begin
      if (who == 0) ic_req_valid  = 1'b0;
      if (who == 1) dcr_req_valid = 1'b0;
      if (who == 2) dcw_req_valid = 1'b0;
    end
    if (who == 2) begin
      for (int b = 0; b < BL; b++) begin
        dcw_data_valid = 1'b1;
        dcw_data       = line_e[b];
        tick();
      end
      dcw_data_valid = 1'b0;
      check("arb_wr_done", dcw_done, 1);
      tick();
    end else begin
      repeat (LAT + BL - 1) tick();
    end
  endtask

  initial begin
    for (int b = 0; b < BL; b++) begin
      line_a[b] = 32'hA000_0000 + b;
      line_b[b] = 32'hB000_0000 + b;
      line_d[b] = 32'hD000_0000 + b;
      line_e[b] = 32'hE000_0000 + b;
    end
    vecs[0] = '{is_ic: 1'b1, addr: 26'h000_0404, exp: line_a};
    vecs[1] = '{is_ic: 1'b0, addr: 26'h000_0200, exp: line_d};
    vecs[2] = '{is_ic: 1'b1, addr: 26'h000_4000, exp: line_b};
    vecs[3] = '{is_ic: 1'b0, addr: 26'h000_0000, exp: line_b};
    vecs[4] = '{is_ic: 1'b0, addr: 26'h000_040C, exp: line_a};
    vecs[5] = '{is_ic: 1'b1, addr: 26'h3FF_C404, exp: line_a};

    rst = 1'b1;
    ic_req_valid = 0; ic_req_addr = '0;
    dcr_req_valid = 0; dcr_req_addr = '0;
    dcw_req_valid = 0; dcw_req_addr = '0;
    dcw_data_valid = 0; dcw_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", dbg_state, 0);
    check("rst_rsp_valid", {ic_rsp_valid, dcr_rsp_valid, ic_rsp_last, dcr_rsp_last}, 0);
    check("rst_ic_data", ic_rsp_data, 0);
    check("rst_dcr_data", dcr_rsp_data, 0);
    check("rst_wr_out", {dcw_data_ready, dcw_done}, 0);
    rst = 1'b0;
    tick();

    do_write(26'h000_0400, line_a, 0);
    do_write(26'h000_0000, line_b, 0);
    do_write(26'h000_0200, line_d, 3);

    // Table of reads; write beats offered outside a write burst must be ignored.
    dcw_data_valid = 1'b1;
    dcw_data       = 32'hDEAD_BEEF;
    for (int v = 0; v < 6; v++) begin
      check("idle_data_ready", dcw_data_ready, 0);
      do_read(vecs[v].is_ic, vecs[v].addr, vecs[v].exp);
    end
    dcw_data_valid = 1'b0;

    // All three requesters at once, each dropping after its grant.
    ic_req_addr = 26'h000_0404; dcr_req_addr = 26'h000_0200; dcw_req_addr = 26'h000_0800;
    ic_req_valid = 1; dcr_req_valid = 1; dcw_req_valid = 1;
    #1;
    arb_step(2, 1);
    arb_step(1, 1);
    arb_step(0, 1);
    do_read(1'b0, 26'h000_0800, line_e);

    // ic held while dcr keeps re-requesting.
    ic_req_valid = 1; dcr_req_valid = 1;
    #1;
    arb_step(1, 0);
    arb_step(1, 0);
    arb_step(0, 0);
    arb_step(1, 0);
    arb_step(1, 0);
    arb_step(0, 0);
    ic_req_valid = 0; dcr_req_valid = 0;
    tick();

    // Reset during beat 1 of an ic burst.
    begin
      bit ok;
      ic_req_addr  = 26'h000_0404;
      ic_req_valid = 1'b1;
      #1;
      wait_ready(0, ok);
      check("rst_seq_grant", ok, 1);
      tick();
      ic_req_valid = 1'b0;
      repeat (LAT) tick();
      check("rst_seq_beat1_valid", ic_rsp_valid, 1);
      check("rst_seq_beat1_data", ic_rsp_data, line_a[1]);
      #2 rst = 1'b1;
      #1;
      check("rst_seq_valid", ic_rsp_valid, 0);
      check("rst_seq_last", ic_rsp_last, 0);
      check("rst_seq_data", ic_rsp_data, 0);
      check("rst_seq_state", dbg_state, 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        check("rst_seq_held", {ic_rsp_valid, ic_rsp_last}, 0);
      end
      rst = 1'b0;
      tick();
      do_read(1'b1, 26'h000_0404, line_a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
